// File: rtl/bitonic_network_4.sv
// Two-stage pipelined bitonic merge of two ascending record pairs into four sorted records.
// Control sidebands ride through the same two register stages so they stay slot-aligned.
module bitonic_network_4 #(
  parameter int DATA_WIDTH = 128,
  parameter int KEY_WIDTH  = 80
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    switch_output,
  input  logic                    stall,
  input  logic [2*DATA_WIDTH-1:0] top_tuple,
  input  logic [2*DATA_WIDTH-1:0] i_elems_0,
  input  logic [2*DATA_WIDTH-1:0] i_elems_1,
  output logic [2*DATA_WIDTH-1:0] o_elems_0,
  output logic [2*DATA_WIDTH-1:0] o_elems_1,
  output logic                    o_switch_output,
  output logic                    o_stall,
  output logic [2*DATA_WIDTH-1:0] o_top_tuple
);

  // Flow control: there is no backpressure. A slot is presented every cycle and
  // the network advances every cycle; stall=1 only tags the slot as a bubble
  // (valid-bar), and that tag emerges on o_stall aligned with the slot's data.

  typedef logic [DATA_WIDTH-1:0] rec_t;

  // Returns {max, min}; equal keys keep the first operand as min.
  function automatic logic [2*DATA_WIDTH-1:0] cmp(input rec_t x, input rec_t y);
    if (x[KEY_WIDTH-1:0] <= y[KEY_WIDTH-1:0]) cmp = {y, x};
    else                                       cmp = {x, y};
  endfunction

  rec_t a0, a1, b0, b1;
  assign a0 = i_elems_0[DATA_WIDTH-1:0];
  assign a1 = i_elems_0[2*DATA_WIDTH-1:DATA_WIDTH];
  assign b0 = i_elems_1[DATA_WIDTH-1:0];
  assign b1 = i_elems_1[2*DATA_WIDTH-1:DATA_WIDTH];

  logic [2*DATA_WIDTH-1:0] c03, c12;
  assign c03 = cmp(a0, b1);
  assign c12 = cmp(a1, b0);

  rec_t                    l0_q, l1_q, l2_q, l3_q;
  logic                    s1_stall_q;
  logic                    s1_switch_q;
  logic [2*DATA_WIDTH-1:0] s1_top_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      l0_q        <= '0;
      l1_q        <= '0;
      l2_q        <= '0;
      l3_q        <= '0;
      s1_stall_q  <= 1'b1;
      s1_switch_q <= 1'b0;
      s1_top_q    <= '0;
    end else begin
      l0_q        <= c03[DATA_WIDTH-1:0];
      l3_q        <= c03[2*DATA_WIDTH-1:DATA_WIDTH];
      l1_q        <= c12[DATA_WIDTH-1:0];
      l2_q        <= c12[2*DATA_WIDTH-1:DATA_WIDTH];
      s1_stall_q  <= stall;
      s1_switch_q <= switch_output;
      s1_top_q    <= top_tuple;
    end
  end

  logic [2*DATA_WIDTH-1:0] c01, c23;
  assign c01 = cmp(l0_q, l1_q);
  assign c23 = cmp(l2_q, l3_q);

  // Each layer-2 comparator output is already {max, min}, i.e. {out1, out0} / {out3, out2}.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_elems_0       <= '0;
      o_elems_1       <= '0;
      o_stall         <= 1'b1;
      o_switch_output <= 1'b0;
      o_top_tuple     <= '0;
    end else begin
      o_elems_0       <= c01;
      o_elems_1       <= c23;
      o_stall         <= s1_stall_q;
      o_switch_output <= s1_switch_q;
      o_top_tuple     <= s1_top_q;
    end
  end

endmodule

// File: tb/tb_bitonic_network_4.sv
// Bench for bitonic_network_4 at 16-bit records with 8-bit keys (payload:key).
// Table vectors, a streaming run and reset sequences share one expected-value queue.
module tb_bitonic_network_4;

  localparam int DW    = 16;
  localparam int KW    = 8;
  localparam int P     = 2 * DW;
  localparam int EXP_W = 3 * P + 2;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         switch_output;
  logic         stall;
  logic [P-1:0] top_tuple;
  logic [P-1:0] i_elems_0;
  logic [P-1:0] i_elems_1;
  logic [P-1:0] o_elems_0;
  logic [P-1:0] o_elems_1;
  logic         o_switch_output;
  logic         o_stall;
  logic [P-1:0] o_top_tuple;

  int checks = 0;
  int errors = 0;

  logic [EXP_W-1:0] exp_q[$];

  bitonic_network_4 #(.DATA_WIDTH(DW), .KEY_WIDTH(KW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .switch_output(switch_output), .stall(stall), .top_tuple(top_tuple),
    .i_elems_0(i_elems_0), .i_elems_1(i_elems_1),
    .o_elems_0(o_elems_0), .o_elems_1(o_elems_1),
    .o_switch_output(o_switch_output), .o_stall(o_stall), .o_top_tuple(o_top_tuple)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [P-1:0] a;
    logic [P-1:0] b;
    logic         st;
    logic         sw;
    logic [P-1:0] top;
    logic [P-1:0] e0;
    logic [P-1:0] e1;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [EXP_W-1:0] pack_exp(input logic [P-1:0] e0, input logic [P-1:0] e1,
                                                input logic st, input logic sw,
                                                input logic [P-1:0] top);
    pack_exp = {e0, e1, st, sw, top};
  endfunction

  task automatic check(input string name, input logic [P-1:0] act, input logic [P-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // scoreboard: compare current outputs against the oldest expectation
  task automatic check_out(input string tag);
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard queue empty", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, ".elems_0"}, o_elems_0, e[EXP_W-1 -: P]);
    check({tag, ".elems_1"}, o_elems_1, e[EXP_W-1-P -: P]);
    check({tag, ".stall"}, {{(P-1){1'b0}}, o_stall}, {{(P-1){1'b0}}, e[P+1]});
    check({tag, ".switch"}, {{(P-1){1'b0}}, o_switch_output}, {{(P-1){1'b0}}, e[P]});
    check({tag, ".top"}, o_top_tuple, e[P-1:0]);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".elems_0"}, o_elems_0, '0);
    check({tag, ".elems_1"}, o_elems_1, '0);
    check({tag, ".stall"}, {{(P-1){1'b0}}, o_stall}, {{(P-1){1'b0}}, 1'b1});
    check({tag, ".switch"}, {{(P-1){1'b0}}, o_switch_output}, '0);
    check({tag, ".top"}, o_top_tuple, '0);
  endtask

  // driver: apply one slot, record its expectation, advance one edge, check the output
  task automatic drive(input string tag, input logic [P-1:0] a, input logic [P-1:0] b,
                       input logic st, input logic sw, input logic [P-1:0] top,
                       input logic [P-1:0] e0, input logic [P-1:0] e1);
    i_elems_0     = a;
    i_elems_1     = b;
    stall         = st;
    switch_output = sw;
    top_tuple     = top;
    exp_q.push_back(pack_exp(e0, e1, st, sw, top));
    @(posedge i_clk);
    #1;
    check_out(tag);
  endtask

  task automatic apply_reset(input string tag);
    i_rst         = 1'b1;
    i_elems_0     = 32'h7777_6666;
    i_elems_1     = 32'h5555_4444;
    stall         = 1'b0;
    switch_output = 1'b1;
    top_tuple     = 32'hDEAD_BEEF;
    @(posedge i_clk);
    #1;
    check_reset_state(tag);
    i_rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(pack_exp('0, '0, 1'b1, 1'b0, '0));
  endtask

  // reference: plain sort of four records by key (used only with distinct keys)
  function automatic logic [2*P-1:0] sort4(input logic [DW-1:0] r[4]);
    logic [DW-1:0] s[4];
    logic [DW-1:0] t;
    s = r;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (s[j][KW-1:0] > s[j+1][KW-1:0]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    sort4 = {s[3], s[2], s[1], s[0]};
  endfunction

  initial begin
    logic [DW-1:0] r[4];
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    logic [2*P-1:0] srt;
    logic [KW-1:0] k;
    bit dup;

    vecs[0] = '{32'h0005_0001, 32'h0003_0002, 1'b0, 1'b0, 32'h0000_0001, 32'h0002_0001, 32'h0005_0003};
    vecs[1] = '{32'hBB07_AA04, 32'hDD07_CC04, 1'b0, 1'b1, 32'h1234_5678, 32'hCC04_AA04, 32'hDD07_BB07};
    vecs[2] = '{32'h0011_0010, 32'h0002_0001, 1'b0, 1'b0, 32'hFFFF_0000, 32'h0002_0001, 32'h0011_0010};
    vecs[3] = '{32'h0002_0001, 32'h0011_0010, 1'b0, 1'b1, 32'h0000_FFFF, 32'h0002_0001, 32'h0011_0010};
    vecs[4] = '{32'h0002_0009, 32'h0005_0001, 1'b0, 1'b0, 32'hA5A5_5A5A, 32'h0005_0001, 32'h0009_0002};
    vecs[5] = '{32'h3307_1103, 32'h4408_2201, 1'b1, 1'b1, 32'h0BAD_F00D, 32'h1103_2201, 32'h4408_3307};
    vecs[6] = '{32'h0105_FF02, 32'h0206_8004, 1'b0, 1'b0, 32'hCAFE_0001, 32'h8004_FF02, 32'h0206_0105};

    i_rst = 1'b1;
    stall = 1'b0;
    switch_output = 1'b0;
    top_tuple = '0;
    i_elems_0 = '0;
    i_elems_1 = '0;
    @(posedge i_clk);
    #1;
    @(posedge i_clk);
    #1;
    check_reset_state("reset");
    i_rst = 1'b0;
    exp_q.push_back(pack_exp('0, '0, 1'b1, 1'b0, '0));

    // table vectors, back-to-back
    for (int i = 0; i < 7; i++)
      drive($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].st, vecs[i].sw,
            vecs[i].top, vecs[i].e0, vecs[i].e1);

    // streaming: distinct random keys, sorted pairs, random sidebands
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 4; i++) begin
        do begin
          k = KW'($urandom_range(0, 255));
          dup = 0;
          for (int j = 0; j < i; j++) if (r[j][KW-1:0] == k) dup = 1;
        end while (dup);
        r[i] = {8'($urandom_range(0, 255)), k};
      end
      srt = sort4(r);
      lo = (r[0][KW-1:0] <= r[1][KW-1:0]) ? r[0] : r[1];
      hi = (r[0][KW-1:0] <= r[1][KW-1:0]) ? r[1] : r[0];
      i_elems_0 = {hi, lo};
      lo = (r[2][KW-1:0] <= r[3][KW-1:0]) ? r[2] : r[3];
      hi = (r[2][KW-1:0] <= r[3][KW-1:0]) ? r[3] : r[2];
      drive($sformatf("stream%0d", n), i_elems_0, {hi, lo},
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), P'($urandom()),
            srt[P-1:0], srt[2*P-1:P]);
    end

    // reset mid-stream with two valid slots in flight
    drive("pre_rst0", vecs[0].a, vecs[0].b, 1'b0, 1'b1, 32'h1111_1111, vecs[0].e0, vecs[0].e1);
    drive("pre_rst1", vecs[2].a, vecs[2].b, 1'b0, 1'b1, 32'h2222_2222, vecs[2].e0, vecs[2].e1);
    apply_reset("mid_reset");
    drive("post_rst0", vecs[1].a, vecs[1].b, 1'b0, 1'b1, 32'h3333_3333, vecs[1].e0, vecs[1].e1);
    drive("post_rst1", vecs[4].a, vecs[4].b, 1'b1, 1'b0, 32'h4444_4444, vecs[4].e0, vecs[4].e1);
    drive("post_rst2", vecs[6].a, vecs[6].b, 1'b0, 1'b0, 32'h5555_5555, vecs[6].e0, vecs[6].e1);
    drive("drain", '0, '0, 1'b1, 1'b0, '0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
